// File: rtl/aes_seq_pkg.sv
// Shared types, state codes and column slice helpers for the AES state sequencer.
package aes_seq_pkg;

  localparam int OP_W   = 3;
  localparam int COL_W  = 32;
  localparam int BYTE_W = 8;
  localparam int BLK_W  = 128;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD   = 3'd0,
    OP_SHIFT  = 3'd1,
    OP_COLX   = 3'd2,
    OP_UNLOAD = 3'd3,
    OP_ADDKEY = 3'd4
  } op_e;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_SHIFT    = 3'd2;
  localparam logic [2:0] ST_COLX     = 3'd3;
  localparam logic [2:0] ST_UNLD_RD  = 3'd4;
  localparam logic [2:0] ST_UNLD_OUT = 3'd5;
  localparam logic [2:0] ST_FIN      = 3'd6;

  // Column c lives at bits [127-32c -: 32], row 0 in the top byte.
  function automatic logic [COL_W-1:0] get_col(input logic [BLK_W-1:0] blk,
                                               input logic [1:0] c);
    case (c)
      2'd0:    return blk[127:96];
      2'd1:    return blk[95:64];
      2'd2:    return blk[63:32];
      default: return blk[31:0];
    endcase
  endfunction

  function automatic logic [BLK_W-1:0] set_col(input logic [BLK_W-1:0] blk,
                                               input logic [1:0] c,
                                               input logic [COL_W-1:0] col);
    logic [BLK_W-1:0] r;
    r = blk;
    case (c)
      2'd0:    r[127:96] = col;
      2'd1:    r[95:64]  = col;
      2'd2:    r[63:32]  = col;
      default: r[31:0]   = col;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_row_rot.sv
// Combinational byte rotator for one 32-bit matrix row; dir = 0 rotates left, 1 right.
module aes_row_rot (
  input  logic [31:0] row_in,
  input  logic [1:0]  amount,
  input  logic        dir,
  output logic [31:0] row_out
);

  logic [1:0] amt_l;

  // A right rotation by n bytes is a left rotation by 4-n.
  always_comb begin
    amt_l = dir ? (2'd0 - amount) : amount;
    case (amt_l)
      2'd0:    row_out = row_in;
      2'd1:    row_out = {row_in[23:0], row_in[31:24]};
      2'd2:    row_out = {row_in[15:0], row_in[31:16]};
      default: row_out = {row_in[7:0],  row_in[31:8]};
    endcase
  end

endmodule

// File: rtl/aes_state_seq.sv
// Command sequencer stepping the 4x4 AES state matrix one row/column per cycle.
// Optional ADD_KEY op and round_key port are enabled by AES_STATE_SEQ_ADDKEY_EN.
//
// state       | meaning
// IDLE        | waiting for a command, cmd_ready high
// LOAD        | writing load block columns 0..3
// SHIFT       | rotating rows 1..3 in place
// COLX        | column 0..3 through xf_out (or key XOR for ADD_KEY)
// UNLD_RD     | reading columns 0..3 into out_data
// UNLD_OUT    | presenting out_data until accepted
// FIN         | done pulse (with err for an illegal op)
module aes_state_seq
  import aes_seq_pkg::*;
#(
  parameter bit INV_SHIFT = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [OP_W-1:0]    cmd_op,
  input  logic [BLK_W-1:0]   load_data,
`ifdef AES_STATE_SEQ_ADDKEY_EN
  input  logic [BLK_W-1:0]   round_key,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLK_W-1:0]   out_data,
  output logic               done,
  output logic               err,
  output logic [COL_W-1:0]   mat_col_in,
  output logic [1:0]         mat_in_idx,
  output logic               mat_in_row_col,
  output logic               mat_we,
  output logic [1:0]         mat_out_idx,
  output logic               mat_out_row_col,
  input  logic [COL_W-1:0]   mat_rd,
  output logic [COL_W-1:0]   xf_in,
  input  logic [COL_W-1:0]   xf_out
);

  logic [2:0]       state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [BLK_W-1:0] out_q, out_d;
  logic             ill_q, ill_d;
  logic [1:0]       row_sel;
  logic [COL_W-1:0] rot_row;
  logic [COL_W-1:0] colx_data;

`ifdef AES_STATE_SEQ_ADDKEY_EN
  logic [BLK_W-1:0] key_q, key_d;
  logic             addkey_q, addkey_d;
`endif

  assign row_sel = cnt_q + 2'd1;

  aes_row_rot u_rot (
    .row_in  (mat_rd),
    .amount  (row_sel),
    .dir     (INV_SHIFT),
    .row_out (rot_row)
  );

`ifdef AES_STATE_SEQ_ADDKEY_EN
  assign colx_data = addkey_q ? (mat_rd ^ get_col(key_q, cnt_q)) : xf_out;
`else
  assign colx_data = xf_out;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    out_d   = out_q;
    ill_d   = ill_q;
`ifdef AES_STATE_SEQ_ADDKEY_EN
    key_d    = key_q;
    addkey_d = addkey_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cnt_d = 2'd0;
          blk_d = load_data;
          ill_d = 1'b0;
`ifdef AES_STATE_SEQ_ADDKEY_EN
          key_d    = round_key;
          addkey_d = (cmd_op == OP_ADDKEY);
`endif
          case (cmd_op)
            OP_LOAD:   state_d = ST_LOAD;
            OP_SHIFT:  state_d = ST_SHIFT;
            OP_COLX:   state_d = ST_COLX;
            OP_UNLOAD: state_d = ST_UNLD_RD;
`ifdef AES_STATE_SEQ_ADDKEY_EN
            OP_ADDKEY: state_d = ST_COLX;
`endif
            default: begin
              state_d = ST_FIN;
              ill_d   = 1'b1;
            end
          endcase
        end
      end
      ST_LOAD, ST_COLX: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = ST_FIN;
      end
      ST_SHIFT: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd2) state_d = ST_FIN;
      end
      ST_UNLD_RD: begin
        cnt_d = cnt_q + 2'd1;
        out_d = set_col(out_q, cnt_q, mat_rd);
        if (cnt_q == 2'd3) state_d = ST_UNLD_OUT;
      end
      ST_UNLD_OUT: if (out_ready) state_d = ST_FIN;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mat_we          = 1'b0;
    mat_col_in      = '0;
    mat_in_idx      = cnt_q;
    mat_in_row_col  = 1'b0;
    mat_out_idx     = cnt_q;
    mat_out_row_col = 1'b0;
    case (state_q)
      ST_LOAD: begin
        mat_we         = 1'b1;
        mat_in_row_col = 1'b1;
        mat_col_in     = get_col(blk_q, cnt_q);
      end
      ST_SHIFT: begin
        mat_we      = 1'b1;
        mat_in_idx  = row_sel;
        mat_out_idx = row_sel;
        mat_col_in  = rot_row;
      end
      ST_COLX: begin
        mat_we          = 1'b1;
        mat_in_row_col  = 1'b1;
        mat_out_row_col = 1'b1;
        mat_col_in      = colx_data;
      end
      ST_UNLD_RD: mat_out_row_col = 1'b1;
      default: ;
    endcase
  end

  assign xf_in     = mat_rd;
  assign cmd_ready = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_UNLD_OUT);
  assign out_data  = out_q;
  assign done      = (state_q == ST_FIN);
  assign err       = (state_q == ST_FIN) & ill_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      blk_q   <= '0;
      out_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      out_q   <= out_d;
      ill_q   <= ill_d;
    end
  end

`ifdef AES_STATE_SEQ_ADDKEY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q    <= '0;
      addkey_q <= 1'b0;
    end else begin
      key_q    <= key_d;
      addkey_q <= addkey_d;
    end
  end
`endif

endmodule

// File: tb/tb_aes_state_seq.sv
// Scoreboard bench for aes_state_seq: lane 0 uses INV_SHIFT=0, lane 1 uses INV_SHIFT=1,
// each with its own behavioural 4x4 matrix and XOR-FF column transform.
`timescale 1ns/1ps
module tb_aes_state_seq;

  localparam logic [2:0] C_LOAD = 3'd0, C_SHIFT = 3'd1, C_COLX = 3'd2, C_UNLOAD = 3'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         cmd_valid[2], cmd_ready[2], out_valid[2], out_ready[2];
  logic         done[2], err[2], mat_we[2], mat_in_row_col[2], mat_out_row_col[2];
  logic [2:0]   cmd_op[2];
  logic [127:0] load_data[2], out_data[2];
  logic [31:0]  mat_col_in[2], mat_rd[2], xf_in[2], xf_out[2];
  logic [1:0]   mat_in_idx[2], mat_out_idx[2];
`ifdef AES_STATE_SEQ_ADDKEY_EN
  logic [127:0] round_key[2];
`endif

  for (genvar g = 0; g < 2; g++) begin : lane
    logic [7:0] mm [4][4];

    aes_state_seq #(.INV_SHIFT((g == 1) ? 1'b1 : 1'b0)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .cmd_valid       (cmd_valid[g]),
      .cmd_ready       (cmd_ready[g]),
      .cmd_op          (cmd_op[g]),
      .load_data       (load_data[g]),
`ifdef AES_STATE_SEQ_ADDKEY_EN
      .round_key       (round_key[g]),
`endif
      .out_valid       (out_valid[g]),
      .out_ready       (out_ready[g]),
      .out_data        (out_data[g]),
      .done            (done[g]),
      .err             (err[g]),
      .mat_col_in      (mat_col_in[g]),
      .mat_in_idx      (mat_in_idx[g]),
      .mat_in_row_col  (mat_in_row_col[g]),
      .mat_we          (mat_we[g]),
      .mat_out_idx     (mat_out_idx[g]),
      .mat_out_row_col (mat_out_row_col[g]),
      .mat_rd          (mat_rd[g]),
      .xf_in           (xf_in[g]),
      .xf_out          (xf_out[g])
    );

    always @(posedge clk) begin
      if (mat_we[g]) begin
        for (int i = 0; i < 4; i++) begin
          if (mat_in_row_col[g]) mm[i][mat_in_idx[g]] <= mat_col_in[g][31-8*i -: 8];
          else                   mm[mat_in_idx[g]][i] <= mat_col_in[g][31-8*i -: 8];
        end
      end
    end

    assign mat_rd[g] = mat_out_row_col[g] ?
      {mm[0][mat_out_idx[g]], mm[1][mat_out_idx[g]], mm[2][mat_out_idx[g]], mm[3][mat_out_idx[g]]} :
      {mm[mat_out_idx[g]][0], mm[mat_out_idx[g]][1], mm[mat_out_idx[g]][2], mm[mat_out_idx[g]][3]};
    assign xf_out[g] = xf_in[g] ^ 32'hFFFF_FFFF;
  end

  int n_cmp = 0, n_bad = 0;
  int done_cnt = 0, err_cnt = 0, we_cnt = 0;
  logic [127:0] exp_q0[$], exp_q1[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  always @(negedge clk) begin
    if (done[0])   done_cnt++;
    if (err[0])    err_cnt++;
    if (mat_we[0]) we_cnt++;
  end

  // Monitor: every accepted output block is compared with the oldest expectation.
  always @(negedge clk) begin
    if (out_valid[0] && out_ready[0]) begin
      if (exp_q0.size() == 0) fail("unexpected_out0");
      else chk("out_data0", out_data[0], exp_q0.pop_front());
    end
    if (out_valid[1] && out_ready[1]) begin
      if (exp_q1.size() == 0) fail("unexpected_out1");
      else chk("out_data1", out_data[1], exp_q1.pop_front());
    end
  end

  task automatic send(input int l, input logic [2:0] op, input logic [127:0] d);
    int k = 0;
    @(negedge clk);
    while (!cmd_ready[l] && k < 50) begin @(negedge clk); k++; end
    if (!cmd_ready[l]) fail("ready_timeout");
    cmd_valid[l] = 1'b1;
    cmd_op[l]    = op;
    load_data[l] = d;
    @(posedge clk);
    #1 cmd_valid[l] = 1'b0;
  endtask

  task automatic wait_done(input int l);
    int k = 0;
    @(negedge clk);
    while (!done[l] && k < 50) begin @(negedge clk); k++; end
    if (!done[l]) fail("done_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int l, input logic [2:0] op, input logic [127:0] d);
    send(l, op, d);
    wait_done(l);
  endtask

  localparam logic [127:0] B1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] S2 = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] B3 = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] FF = {128{1'b1}};

  initial begin
    int d0, e0, w0, k;
    reset_n = 1'b0;
    for (int l = 0; l < 2; l++) begin
      cmd_valid[l] = 1'b0; cmd_op[l] = 3'd0; load_data[l] = '0; out_ready[l] = 1'b1;
`ifdef AES_STATE_SEQ_ADDKEY_EN
      round_key[l] = '0;
`endif
    end
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 128'(cmd_ready[0]), 128'd1);
    chk("rst_out_valid", 128'(out_valid[0]), 128'd0);
    chk("rst_done", 128'(done[0]), 128'd0);
    chk("rst_err", 128'(err[0]), 128'd0);
    chk("rst_mat_we", 128'(mat_we[0]), 128'd0);
    chk("rst_out_data", out_data[0], 128'd0);
    reset_n = 1'b1;

    // Load/unload round trip
    d0 = done_cnt; e0 = err_cnt;
    run(0, C_LOAD, B1);
    exp_q0.push_back(B1);
    run(0, C_UNLOAD, '0);
    chk("rt_done_count", 128'(done_cnt - d0), 128'd2);
    chk("rt_err_count", 128'(err_cnt - e0), 128'd0);

    // ShiftRows forward on lane 0, inverse of that result on lane 1
    run(0, C_LOAD, B2);
    run(0, C_SHIFT, '0);
    exp_q0.push_back(S2);
    run(0, C_UNLOAD, '0);
    run(1, C_LOAD, S2);
    run(1, C_SHIFT, '0);
    exp_q1.push_back(B2);
    run(1, C_UNLOAD, '0);

    // Column pass through the XOR-FF transform
    run(0, C_LOAD, '0);
    w0 = we_cnt;
    run(0, C_COLX, '0);
    chk("colx_we_cycles", 128'(we_cnt - w0), 128'd4);
    exp_q0.push_back(FF);
    run(0, C_UNLOAD, '0);

    // Output back-pressure with stray command pulses
    out_ready[0] = 1'b0;
    exp_q0.push_back(FF);
    send(0, C_UNLOAD, '0);
    k = 0;
    @(negedge clk);
    while (!out_valid[0] && k < 20) begin @(negedge clk); k++; end
    if (!out_valid[0]) fail("stall_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_valid", 128'(out_valid[0]), 128'd1);
      chk("stall_out_data", out_data[0], FF);
      chk("stall_cmd_ready", 128'(cmd_ready[0]), 128'd0);
      cmd_valid[0] = (i % 2 == 0); cmd_op[0] = C_LOAD; load_data[0] = B1;
      @(negedge clk);
    end
    @(posedge clk);
    #1 cmd_valid[0] = 1'b0; out_ready[0] = 1'b1;
    @(negedge clk);
    chk("hs_cmd_ready", 128'(cmd_ready[0]), 128'd0);
    @(negedge clk);
    chk("fin_done", 128'(done[0]), 128'd1);
    chk("fin_cmd_ready", 128'(cmd_ready[0]), 128'd0);
    @(negedge clk);
    chk("post_fin_cmd_ready", 128'(cmd_ready[0]), 128'd1);
    chk("post_fin_done", 128'(done[0]), 128'd0);
    exp_q0.push_back(FF);
    run(0, C_UNLOAD, '0);

    // Reset in the middle of a SHIFT
    send(0, C_SHIFT, '0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    d0 = done_cnt;
    chk("midrst_cmd_ready", 128'(cmd_ready[0]), 128'd1);
    chk("midrst_mat_we", 128'(mat_we[0]), 128'd0);
    chk("midrst_done", 128'(done[0]), 128'd0);
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("midrst_no_done", 128'(done_cnt - d0), 128'd0);
    run(0, C_LOAD, B3);
    exp_q0.push_back(B3);
    run(0, C_UNLOAD, '0);

    // Illegal op 6
    w0 = we_cnt;
    send(0, 3'd6, '0);
    @(negedge clk);
    chk("ill6_done", 128'(done[0]), 128'd1);
    chk("ill6_err", 128'(err[0]), 128'd1);
    @(negedge clk);
    chk("ill6_done_pulse", 128'(done[0]), 128'd0);
    chk("ill6_no_we", 128'(we_cnt - w0), 128'd0);

`ifdef AES_STATE_SEQ_ADDKEY_EN
    run(0, C_LOAD, B1);
    round_key[0] = B1;
    e0 = err_cnt;
    run(0, 3'd4, '0);
    round_key[0] = '0;
    chk("addkey_err", 128'(err_cnt - e0), 128'd0);
    exp_q0.push_back('0);
    run(0, C_UNLOAD, '0);
`else
    w0 = we_cnt;
    send(0, 3'd4, '0);
    @(negedge clk);
    chk("op4_done", 128'(done[0]), 128'd1);
    chk("op4_err", 128'(err[0]), 128'd1);
    @(negedge clk);
    chk("op4_no_we", 128'(we_cnt - w0), 128'd0);
`endif

    repeat (4) @(negedge clk);
    chk("sb_left0", 128'(exp_q0.size()), 128'd0);
    chk("sb_left1", 128'(exp_q1.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_state_seq.md
Name: aes_state_seq

Overview:
- Command-driven sequencer for the 4x4 AES state matrix. The matrix has a synchronous row/column write port and a combinational row/column read port.
- Accepts one command at a time (LOAD, SHIFT_ROWS, COL_PASS, UNLOAD) and steps the matrix ports one row or column per cycle.
- Routes columns through an external combinational column transform (e.g. MixColumns/SubWord).
- Sits between the round controller and the state matrix.

Parameters:
- INV_SHIFT, 0, 0 = ShiftRows rotates row r left by r bytes (encrypt); 1 = rotates right by r bytes (InvShiftRows).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  3  0=LOAD, 1=SHIFT_ROWS, 2=COL_PASS, 3=UNLOAD, 4=ADD_KEY (optional feature), 5-7 illegal
- load_data  in  128  block for LOAD; column c = bits [127-32c -: 32], byte order row0..row3 MSB-first
- out_valid  out  1  unloaded block valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  128  unloaded block, same packing as load_data
- done  out  1  one-cycle pulse when a command completes
- err  out  1  one-cycle pulse with done for an illegal op
- mat_col_in  out  32  matrix write data
- mat_in_idx  out  2  matrix write index
- mat_in_row_col  out  1  0 = row, 1 = column
- mat_we  out  1  matrix write enable
- mat_out_idx  out  2  matrix read index
- mat_out_row_col  out  1  0 = row, 1 = column
- mat_rd  in  32  matrix combinational read data
- xf_in  out  32  column to transform (= mat_rd)
- xf_out  in  32  transformed column, combinational

Behaviour:
- Reset (async, any state): FSM -> IDLE; counter = 0; out_data = 0. All outputs 0 except cmd_ready = 1. Any in-flight operation is abandoned with no done pulse.
- FSM states: IDLE, LOAD, SHIFT, COLX, UNLD_RD, UNLD_OUT, FIN. The 2-bit counter cnt is cleared on every command accept.
- Accept: cmd_valid & cmd_ready in cycle T. The op is latched; load_data is sampled at T and held internally.
- LOAD: cycles T+1..T+4 write column cnt = 0..3 (mat_we = 1, mat_in_row_col = 1) -> FIN.
- SHIFT: cycles T+1..T+3 handle row r = cnt+1 (rows 1..3; row 0 untouched).
  - Read row r (mat_out_row_col = 0) and write the rotated row r in the same cycle.
  - Rotation amount is r bytes; direction is set by INV_SHIFT.
  - -> FIN after row 3.
- COLX: cycles T+1..T+4 read column c and write xf_out to column c in the same cycle -> FIN.
- UNLD_RD: cycles T+1..T+4 read column c into out_data slot c -> UNLD_OUT.
- UNLD_OUT: out_valid = 1 from T+5. out_data is held stable until out_valid & out_ready -> FIN.
- FIN: done = 1 for one cycle, then -> IDLE. cmd_ready returns high the cycle after FIN.
- Illegal op: no matrix writes; FIN with err = 1.
- Read-modify-write in one cycle is legal because matrix reads are combinational and writes land at the next edge.
- mat_we is 0 in every state other than LOAD, SHIFT and COLX.
- cmd_valid is ignored while busy; cmd_op and load_data are don't-care outside the accept cycle.
- out_ready while out_valid = 0 has no effect.

Optional Feature:
- Macro: AES_STATE_SEQ_ADDKEY_EN.
- With the macro defined:
  - Adds input port round_key [127:0], sampled at accept and packed like load_data.
  - Op 4 (ADD_KEY) runs 4 column cycles writing mat_rd ^ key column c -> FIN.
- Without the macro: no round_key port; op 4 is illegal and gives done with err = 1.

Decomposition:
- Package aes_seq_pkg:
  - op enum (OP_LOAD, OP_SHIFT, OP_COLX, OP_UNLOAD, OP_ADDKEY)
  - FSM state enum
  - OP_W = 3
  - column/byte slice helper constants
- Sub-module aes_row_rot: combinational 32-bit byte rotator with inputs amount[1:0] and dir. Used by SHIFT.

Test Plan:
- LOAD 00112233445566778899aabbccddeeff, then UNLOAD with out_ready = 1 -> out_data 00112233445566778899aabbccddeeff. done pulses twice, err never asserts.
- LOAD 000102030405060708090a0b0c0d0e0f, SHIFT_ROWS, UNLOAD, all with INV_SHIFT = 0 -> 00050a0f04090e03080d02070c01060b. Repeat with INV_SHIFT = 1 on that result -> original block.
- COL_PASS with bench xf_out = xf_in ^ FFFFFFFF after LOAD of all-zero block, then UNLOAD -> all-FF block; mat_we high exactly 4 cycles.
- UNLOAD with out_ready low 5 cycles -> out_valid held high and out_data stable across all 5 cycles; cmd_ready low until 1 cycle after FIN; extra cmd_valid pulses ignored.
- reset_n low during SHIFT cycle T+2 -> immediately cmd_ready = 1, mat_we = 0, no done; a subsequent LOAD/UNLOAD round-trips correctly.
- cmd_op = 6 -> done and err both high for one cycle at T+1, mat_we never high. With AES_STATE_SEQ_ADDKEY_EN: ADD_KEY of key = block -> UNLOAD gives all zeros.
